// File: rtl/exec_unit_if.sv
// Control bus carrying the shared clock and the asynchronous active-high reset.
interface ctrl_bus_if;
  logic clk;
  logic rst;

  // The execution unit only consumes clock and reset from this bus.
  modport master (
    input clk,
    input rst
  );
endinterface

// File: rtl/exec_unit.sv
// Execution stage of a tiny 4-bit CPU: a FETCH/EXEC/HALT sequencer plus the
// A/B/out_port/carry/pc architectural state and the single 5-bit adder that
// feeds every register write.

package exec_unit_pkg;

  // Decoded instruction as delivered (already registered) by the decoder.
  typedef enum logic [3:0] {
    NOP       = 4'h0,
    ADD_A_IMM = 4'h1,
    ADD_B_IMM = 4'h2,
    MOV_A_IMM = 4'h3,
    MOV_B_IMM = 4'h4,
    MOV_A_B   = 4'h5,
    MOV_B_A   = 4'h6,
    JMP_IMM   = 4'h7,
    JNC_IMM   = 4'h8,
    IN_A      = 4'h9,
    IN_B      = 4'hA,
    OUT_B     = 4'hB,
    OUT_IMM   = 4'hC,
    INVALID   = 4'hF
  } opecode_t;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

endpackage

module exec_unit
  import exec_unit_pkg::*;
(
  ctrl_bus_if.master     ctrl,
  input  opecode_t       opecode,
  input  logic [3:0]     imm,
  input  logic           step,
  input  logic [3:0]     in_port,
  output logic [3:0]     pc,
  output logic [3:0]     reg_a,
  output logic [3:0]     reg_b,
  output logic [3:0]     out_port,
  output logic           carry,
  output logic           halted,
  output logic           exec_phase
);

  state_t     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] out_q, out_d;
  logic       carry_q, carry_d;

  logic [3:0] alu_src;
  logic [3:0] alu_imm;
  logic [4:0] alu_sum;
  logic       opcode_valid;
  logic       commit;

  // Opcode decode: pick the adder source, mask the immediate for NOP and flag
  // anything that is not a defined instruction (unused encodings halt too).
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    alu_src      = 4'd0;
    alu_imm      = imm;
    opcode_valid = 1'b1;
    case (opecode)
      ADD_A_IMM, MOV_B_A:        alu_src = a_q;
      ADD_B_IMM, MOV_A_B, OUT_B: alu_src = b_q;
      IN_A, IN_B:                alu_src = in_port;
      NOP:                       alu_imm = 4'd0;
      MOV_A_IMM, MOV_B_IMM, OUT_IMM, JMP_IMM, JNC_IMM: ;
      default:                   opcode_valid = 1'b0;
    endcase
    alu_sum = {1'b0, alu_src} + {1'b0, alu_imm};
  end

  // An instruction retires only on the EXEC->FETCH edge of a valid opcode.
  assign commit = step && (state_q == ST_EXEC) && opcode_valid;

  // FSM state register.
  always_ff @(posedge ctrl.clk or posedge ctrl.rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    if (ctrl.rst) state_q <= ST_FETCH;
    else          state_q <= state_d;
  end

  // FSM next-state logic; step low freezes the sequencer, HALT is sticky.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: if (step) state_d = ST_EXEC;
      ST_EXEC:  if (step) state_d = opcode_valid ? ST_FETCH : ST_HALT;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_FETCH;
    endcase
  end

  // FSM outputs decoded straight from the state flops, so reset clears them
  // immediately.
  always_comb begin
    halted     = (state_q == ST_HALT);
    exec_phase = (state_q == ST_EXEC);
  end

  // Architectural next-state: only a commit changes anything. Carry always
  // takes the adder carry-out; JNC looks at the carry from before this commit.
  always_comb begin
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    carry_d = carry_q;
    if (commit) begin
      carry_d = alu_sum[4];
      pc_d    = pc_q + 4'd1;
      case (opecode)
        ADD_A_IMM, MOV_A_IMM, MOV_A_B, IN_A: a_d   = alu_sum[3:0];
        ADD_B_IMM, MOV_B_IMM, MOV_B_A, IN_B: b_d   = alu_sum[3:0];
        OUT_B, OUT_IMM:                      out_d = alu_sum[3:0];
        JMP_IMM:                             pc_d  = imm;
        JNC_IMM:                             if (!carry_q) pc_d = imm;
        default: ;
      endcase
    end
  end

  // Architectural registers, all cleared asynchronously by reset.
  always_ff @(posedge ctrl.clk or posedge ctrl.rst) begin
    if (ctrl.rst) begin
      pc_q    <= 4'd0;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      out_q   <= 4'd0;
      carry_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      carry_q <= carry_d;
    end
  end

  assign pc       = pc_q;
  assign reg_a    = a_q;
  assign reg_b    = b_q;
  assign out_port = out_q;
  assign carry    = carry_q;

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: each committed (or halting) instruction
// pushes its hand-computed architectural result; a monitor pops and compares
// whenever the DUT leaves EXEC.
module tb_exec_unit;
  import exec_unit_pkg::*;

  typedef struct packed {
    logic       halted;
    logic [3:0] pc;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] out;
    logic       c;
  } exp_t;

  ctrl_bus_if ctrl();

  opecode_t   opecode;
  logic [3:0] imm;
  logic       step;
  logic [3:0] in_port;
  logic [3:0] pc;
  logic [3:0] reg_a;
  logic [3:0] reg_b;
  logic [3:0] out_port;
  logic       carry;
  logic       halted;
  logic       exec_phase;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic prev_exec = 1'b0;

  exec_unit dut (
    .ctrl       (ctrl),
    .opecode    (opecode),
    .imm        (imm),
    .step       (step),
    .in_port    (in_port),
    .pc         (pc),
    .reg_a      (reg_a),
    .reg_b      (reg_b),
    .out_port   (out_port),
    .carry      (carry),
    .halted     (halted),
    .exec_phase (exec_phase)
  );

  initial ctrl.clk = 1'b0;
  always #5 ctrl.clk = ~ctrl.clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_state(input string name, input logic [3:0] e_pc, input logic [3:0] e_a,
                             input logic [3:0] e_b, input logic [3:0] e_out, input logic e_c,
                             input logic e_halt, input logic e_exec);
    check({name, ".pc"},         {4'd0, pc},       {4'd0, e_pc});
    check({name, ".reg_a"},      {4'd0, reg_a},    {4'd0, e_a});
    check({name, ".reg_b"},      {4'd0, reg_b},    {4'd0, e_b});
    check({name, ".out_port"},   {4'd0, out_port}, {4'd0, e_out});
    check({name, ".carry"},      {7'd0, carry},    {7'd0, e_c});
    check({name, ".halted"},     {7'd0, halted},   {7'd0, e_halt});
    check({name, ".exec_phase"}, {7'd0, exec_phase}, {7'd0, e_exec});
  endtask

  // Monitor: a drop of exec_phase outside reset means an instruction retired
  // or the unit halted; compare against the oldest expectation.
  always @(negedge ctrl.clk or posedge ctrl.rst) begin
    if (ctrl.rst) begin
      prev_exec = 1'b0;
    end else begin
      if (prev_exec && !exec_phase) begin
        if (exp_q.size() == 0) begin
          check("unexpected_retire", 8'd1, 8'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb.halted",   {7'd0, halted},   {7'd0, e.halted});
          check("sb.pc",       {4'd0, pc},       {4'd0, e.pc});
          check("sb.reg_a",    {4'd0, reg_a},    {4'd0, e.a});
          check("sb.reg_b",    {4'd0, reg_b},    {4'd0, e.b});
          check("sb.out_port", {4'd0, out_port}, {4'd0, e.out});
          check("sb.carry",    {7'd0, carry},    {7'd0, e.c});
        end
      end
      prev_exec = exec_phase;
    end
  end

  // From FETCH (just after an edge) into EXEC; garbage on the decoder inputs
  // must be ignored while fetching.
  task automatic fetch_to_exec();
    opecode = INVALID;
    imm     = 4'hA;
    step    = 1'b1;
    @(posedge ctrl.clk);
    #1;
    check("enter_exec", {7'd0, exec_phase}, 8'd1);
  endtask

  // Present one instruction in EXEC and record its expected retirement.
  task automatic exec_commit(input opecode_t op, input logic [3:0] iv, input logic e_halt,
                             input logic [3:0] e_pc, input logic [3:0] e_a, input logic [3:0] e_b,
                             input logic [3:0] e_out, input logic e_c);
    exp_t e;
    opecode = op;
    imm     = iv;
    step    = 1'b1;
    e = '{halted: e_halt, pc: e_pc, a: e_a, b: e_b, out: e_out, c: e_c};
    exp_q.push_back(e);
    @(posedge ctrl.clk);
    #1;
    step = 1'b0;
  endtask

  task automatic do_instr(input opecode_t op, input logic [3:0] iv, input logic [3:0] e_pc,
                          input logic [3:0] e_a, input logic [3:0] e_b, input logic [3:0] e_out,
                          input logic e_c);
    fetch_to_exec();
    exec_commit(op, iv, 1'b0, e_pc, e_a, e_b, e_out, e_c);
  endtask

  initial begin
    ctrl.rst = 1'b1;
    step     = 1'b0;
    opecode  = NOP;
    imm      = 4'd0;
    in_port  = 4'd0;
    repeat (2) @(posedge ctrl.clk);
    #1;
    check_state("reset", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    ctrl.rst = 1'b0;
    @(posedge ctrl.clk);
    #1;
    check_state("idle_no_step", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    //        op         imm    pc     a      b      out    c
    do_instr(MOV_A_IMM, 4'd9,  4'd1,  4'd9,  4'd0,  4'd0,  1'b0);
    do_instr(ADD_A_IMM, 4'd9,  4'd2,  4'd2,  4'd0,  4'd0,  1'b1);
    do_instr(JNC_IMM,   4'd7,  4'd3,  4'd2,  4'd0,  4'd0,  1'b0);
    do_instr(JNC_IMM,   4'd7,  4'd7,  4'd2,  4'd0,  4'd0,  1'b0);
    in_port = 4'd5;
    do_instr(IN_B,      4'd3,  4'd8,  4'd2,  4'd8,  4'd0,  1'b0);
    do_instr(OUT_B,     4'd0,  4'd9,  4'd2,  4'd8,  4'd8,  1'b0);
    do_instr(MOV_B_A,   4'd15, 4'd10, 4'd2,  4'd1,  4'd8,  1'b1);
    do_instr(MOV_A_B,   4'd0,  4'd11, 4'd1,  4'd1,  4'd8,  1'b0);
    do_instr(ADD_B_IMM, 4'd15, 4'd12, 4'd1,  4'd0,  4'd8,  1'b1);
    do_instr(NOP,       4'd5,  4'd13, 4'd1,  4'd0,  4'd8,  1'b0);
    do_instr(OUT_IMM,   4'd6,  4'd14, 4'd1,  4'd0,  4'd6,  1'b0);
    in_port = 4'd15;
    do_instr(IN_A,      4'd1,  4'd15, 4'd0,  4'd0,  4'd6,  1'b1);
    do_instr(NOP,       4'd0,  4'd0,  4'd0,  4'd0,  4'd6,  1'b0);
    do_instr(JMP_IMM,   4'd4,  4'd4,  4'd0,  4'd0,  4'd6,  1'b0);
    do_instr(MOV_B_IMM, 4'd3,  4'd5,  4'd0,  4'd3,  4'd6,  1'b0);

    // step low in FETCH: nothing moves for 10 cycles.
    step = 1'b0;
    opecode = ADD_A_IMM;
    imm = 4'd1;
    for (int i = 0; i < 10; i++) begin
      @(posedge ctrl.clk);
      #1;
      check_state("hold_fetch", 4'd5, 4'd0, 4'd3, 4'd6, 1'b0, 1'b0, 1'b0);
    end
    // step low in EXEC: no commit for 10 cycles, then the commit lands.
    fetch_to_exec();
    step = 1'b0;
    opecode = ADD_A_IMM;
    imm = 4'd2;
    for (int i = 0; i < 10; i++) begin
      @(posedge ctrl.clk);
      #1;
      check_state("hold_exec", 4'd5, 4'd0, 4'd3, 4'd6, 1'b0, 1'b0, 1'b1);
    end
    exec_commit(ADD_A_IMM, 4'd2, 1'b0, 4'd6, 4'd2, 4'd3, 4'd6, 1'b0);

    // Reset pulse in the middle of EXEC of ADD_A_IMM: no commit, all cleared.
    fetch_to_exec();
    opecode = ADD_A_IMM;
    imm = 4'd5;
    step = 1'b1;
    #1 ctrl.rst = 1'b1;
    #1 check_state("rst_mid_exec", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    #1 ctrl.rst = 1'b0;
    @(posedge ctrl.clk);
    #1;
    check_state("first_step_after_rst", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    exec_commit(MOV_A_IMM, 4'd3, 1'b0, 4'd1, 4'd3, 4'd0, 4'd0, 1'b0);

    // INVALID in EXEC halts with state frozen; later steps are ignored.
    fetch_to_exec();
    exec_commit(INVALID, 4'd9, 1'b1, 4'd1, 4'd3, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step = 1'b1;
      opecode = (i % 2 == 0) ? JMP_IMM : ADD_A_IMM;
      imm = 4'd7;
      @(posedge ctrl.clk);
      #1;
      check_state("halt_frozen", 4'd1, 4'd3, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    end
    step = 1'b0;
    #2 ctrl.rst = 1'b1;
    #1 check_state("rst_in_halt", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    #1 ctrl.rst = 1'b0;
    repeat (2) @(posedge ctrl.clk);
    #1;
    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
